// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP-1 output display driver:
// converter state encoding, seven-segment patterns and the digit count.
package sap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    localparam int DIGITS = 3;

    // Segment order {g,f,e,d,c,b,a}, active-low for a common-anode display.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction: a digit of 5 or more would overflow past 9 when doubled.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to seven-segment decoder; non-decimal nibbles
// and an explicit blank request both produce a dark digit.
module seg7_decode
    import sap_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        if (!blank_i) begin
            case (nibble_i)
                4'd0:    seg_n_o = SEG_0;
                4'd1:    seg_n_o = SEG_1;
                4'd2:    seg_n_o = SEG_2;
                4'd3:    seg_n_o = SEG_3;
                4'd4:    seg_n_o = SEG_4;
                4'd5:    seg_n_o = SEG_5;
                4'd6:    seg_n_o = SEG_6;
                4'd7:    seg_n_o = SEG_7;
                4'd8:    seg_n_o = SEG_8;
                4'd9:    seg_n_o = SEG_9;
                default: seg_n_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sap_display_driver.sv
// SAP-1 output display: serial binary-to-BCD converter feeding a
// three-digit multiplexed common-anode seven-segment scan.
//
// state    | meaning
// ST_IDLE  | waiting for a strobe; also launches a queued (pending) value, busy held high then
// ST_SHIFT | one double-dabble step per cycle, 8 steps
// ST_DONE  | commit scratch result to bcd
module sap_display_driver
    import sap_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        base_clock,
    input  logic        CLR,
    input  logic [7:0]  data_in,
    input  logic        load_strobe,
    output logic        busy,
    output logic [11:0] bcd,
    output logic [6:0]  seg_n,
    output logic [2:0]  an_n
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    conv_state_e       state_q, state_d;
    logic [7:0]        bin_q, bin_d;
    logic [11:0]       scratch_q, scratch_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [7:0]        pend_data_q, pend_data_d;
    logic [11:0]       bcd_q, bcd_d;
    logic [11:0]       adj;

    logic [PW-1:0]     presc_q, presc_d;
    logic [1:0]        sel_q, sel_d;
    logic [6:0]        seg_n_q;
    logic [DIGITS-1:0] an_n_q, an_n_d;
    logic [3:0]        digit;
    logic              blank;
    logic [6:0]        seg_dec;

    assign adj = {dabble_adj(scratch_q[11:8]), dabble_adj(scratch_q[7:4]), dabble_adj(scratch_q[3:0])};

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        bcd_d       = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    bin_d     = pend_data_q;
                    scratch_d = '0;
                    cnt_d     = 4'd8;
                    state_d   = ST_SHIFT;
                    pend_d    = load_strobe;
                    if (load_strobe) pend_data_d = data_in;
                end else if (load_strobe) begin
                    bin_d     = data_in;
                    scratch_d = '0;
                    cnt_d     = 4'd8;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scratch_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_DONE;
                if (load_strobe) begin
                    pend_d      = 1'b1;
                    pend_data_d = data_in;
                end
            end
            ST_DONE: begin
                bcd_d   = scratch_q;
                state_d = ST_IDLE;
                if (load_strobe) begin
                    pend_d      = 1'b1;
                    pend_data_d = data_in;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan runs freely from the committed bcd, never from the scratch register.
    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        sel_d   = sel_q;
        if (presc_q == PRESC_LAST) sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;

        digit = bcd_q[3:0];
        blank = 1'b0;
        case (sel_q)
            2'd1: begin
                digit = bcd_q[7:4];
                blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
            end
            2'd2: begin
                digit = bcd_q[11:8];
                blank = (bcd_q[11:8] == 4'd0);
            end
            default: ;
        endcase
        an_n_d = ~(DIGITS'(1) << sel_q);
    end

    seg7_decode u_seg7_decode (
        .nibble_i (digit),
        .blank_i  (blank),
        .seg_n_o  (seg_dec)
    );

    always_ff @(posedge base_clock) begin
        if (CLR) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            bcd_q       <= '0;
            presc_q     <= '0;
            sel_q       <= '0;
            seg_n_q     <= SEG_BLANK;
            an_n_q      <= '1;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            bcd_q       <= bcd_d;
            presc_q     <= presc_d;
            sel_q       <= sel_d;
            seg_n_q     <= seg_dec;
            an_n_q      <= an_n_d;
        end
    end

    assign busy  = (state_q != ST_IDLE) || pend_q;
    assign bcd   = bcd_q;
    assign seg_n = seg_n_q;
    assign an_n  = an_n_q;

endmodule
